// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline always wins the register file port, MDU results queue in a small FIFO.
// Latency 1 cycle to rf_*; mdu_ready drops while the FIFO is full. Optional squash: WB_SQUASH_EN.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_wsel,
    input  logic [31:0] pipe_wdat,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_wsel,
    input  logic [31:0] mdu_wdat,
    output logic        mdu_ready,
    output logic        rf_wen,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic [31:0] pending_mask
);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [2:0] LAST    = 3'(DEPTH - 1);

    // Storage spans the full 3-bit pointer space; only DEPTH slots are ever addressed.
    logic [4:0]  q_sel [8];
    logic [31:0] q_dat [8];
    logic [2:0]  rd_ptr, wr_ptr;
    logic [3:0]  count;

    logic accept, fifo_empty, push, pop, head_vld;

    assign mdu_ready  = (count < DEPTH_C);
    assign accept     = mdu_valid && mdu_ready;
    assign fifo_empty = (count == 4'd0);
    assign push       = accept && (pipe_wen || !fifo_empty);
    assign pop        = !pipe_wen && !fifo_empty;

`ifdef WB_SQUASH_EN
    logic [7:0] q_vld;
    logic       squash;
    assign squash   = pipe_wen && (pipe_wsel != 5'd0);
    assign head_vld = q_vld[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_vld <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (squash && q_sel[i] == pipe_wsel)
                    q_vld[i] <= 1'b0;
            end
            if (push)
                q_vld[wr_ptr] <= !(squash && mdu_wsel == pipe_wsel);
        end
    end
`else
    assign head_vld = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (push) begin
            q_sel[wr_ptr] <= mdu_wsel;
            q_dat[wr_ptr] <= mdu_wdat;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rf_wen  <= 1'b0;
            rf_wsel <= '0;
            rf_wdat <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? 3'd0 : wr_ptr + 3'd1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? 3'd0 : rd_ptr + 3'd1;
            count <= count + 4'(push) - 4'(pop);

            if (pipe_wen) begin
                rf_wen  <= (pipe_wsel != 5'd0);
                rf_wsel <= pipe_wsel;
                rf_wdat <= pipe_wdat;
            end else if (!fifo_empty) begin
                rf_wen  <= head_vld && (q_sel[rd_ptr] != 5'd0);
                rf_wsel <= q_sel[rd_ptr];
                rf_wdat <= q_dat[rd_ptr];
            end else if (accept) begin
                rf_wen  <= (mdu_wsel != 5'd0);
                rf_wsel <= mdu_wsel;
                rf_wdat <= mdu_wdat;
            end else begin
                rf_wen  <= 1'b0;
            end
        end
    end

    // A slot is occupied when its distance from the head is below count.
    always_comb begin
        int off;
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = i - int'(rd_ptr);
            if (off < 0)
                off = off + DEPTH;
`ifdef WB_SQUASH_EN
            if (off < int'(count) && q_vld[i])
`else
            if (off < int'(count))
`endif
                pending_mask[q_sel[i]] = 1'b1;
        end
        if (rf_wen)
            pending_mask[rf_wsel] = 1'b1;
        pending_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with DEPTH = 2; squash expectations follow WB_SQUASH_EN.
module tb_wb_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        pipe_wen;
    logic [4:0]  pipe_wsel;
    logic [31:0] pipe_wdat;
    logic        mdu_valid;
    logic [4:0]  mdu_wsel;
    logic [31:0] mdu_wdat;
    logic        mdu_ready;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [31:0] pending_mask;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(.DEPTH(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
        .mdu_valid(mdu_valid), .mdu_wsel(mdu_wsel), .mdu_wdat(mdu_wdat),
        .mdu_ready(mdu_ready),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .pending_mask(pending_mask)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic wen, input logic [4:0] sel,
                           input logic [31:0] dat, input logic [31:0] mask);
        chk({tag, ".wen"}, {31'd0, rf_wen}, {31'd0, wen});
        if (wen) begin
            chk({tag, ".sel"}, {27'd0, rf_wsel}, {27'd0, sel});
            chk({tag, ".dat"}, rf_wdat, dat);
        end
        chk({tag, ".mask"}, pending_mask, mask);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pipe(input logic en, input logic [4:0] sel, input logic [31:0] dat);
        pipe_wen = en; pipe_wsel = sel; pipe_wdat = dat;
    endtask

    task automatic mdu(input logic vld, input logic [4:0] sel, input logic [31:0] dat);
        mdu_valid = vld; mdu_wsel = sel; mdu_wdat = dat;
    endtask

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    initial begin
        // Reset with both sources active
        nRST = 1'b0;
        pipe(1'b1, 5'd5, 32'h1);
        mdu(1'b1, 5'd7, 32'h2);
        tick(); tick();
        chk_out("reset", 1'b0, 5'd0, 32'd0, 32'd0);
        chk("reset.ready", {31'd0, mdu_ready}, 32'd1);
        chk("reset.wsel", {27'd0, rf_wsel}, 32'd0);
        chk("reset.wdat", rf_wdat, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        nRST = 1'b1;

        // Uncontended pipe write
        pipe(1'b1, 5'd5, 32'h1234);
        tick();
        chk_out("pipe_r5", 1'b1, 5'd5, 32'h1234, bit_of(5));
        pipe(1'b0, 5'd0, 32'd0);

        // Uncontended MDU write, direct path
        mdu(1'b1, 5'd7, 32'hCAFE);
        tick();
        chk_out("mdu_r7", 1'b1, 5'd7, 32'hCAFE, bit_of(7));
        chk("mdu_r7.ready", {31'd0, mdu_ready}, 32'd1);
        mdu(1'b0, 5'd0, 32'd0);
        tick();
        chk_out("idle1", 1'b0, 5'd0, 32'd0, 32'd0);

        // Collision: pipe r3 wins, MDU r9 queued
        pipe(1'b1, 5'd3, 32'hA);
        mdu(1'b1, 5'd9, 32'hB);
        tick();
        chk_out("coll_n1", 1'b1, 5'd3, 32'hA, bit_of(3) | bit_of(9));
        chk("coll_n1.ready", {31'd0, mdu_ready}, 32'd1);
        pipe(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        tick();
        chk_out("coll_n2", 1'b1, 5'd9, 32'hB, bit_of(9));
        tick();
        chk_out("coll_idle", 1'b0, 5'd0, 32'd0, 32'd0);

        // Full FIFO under sustained pipe traffic
        pipe(1'b1, 5'd20, 32'h20);
        mdu(1'b1, 5'd10, 32'h10);
        tick();
        chk("full1.ready", {31'd0, mdu_ready}, 32'd1);
        pipe(1'b1, 5'd21, 32'h21);
        mdu(1'b1, 5'd11, 32'h11);
        tick();
        chk("full2.ready", {31'd0, mdu_ready}, 32'd0);
        chk_out("full2", 1'b1, 5'd21, 32'h21, bit_of(21) | bit_of(10) | bit_of(11));
        pipe(1'b1, 5'd22, 32'h22);
        mdu(1'b1, 5'd12, 32'h12);
        tick();
        chk("full3.ready", {31'd0, mdu_ready}, 32'd0);
        chk_out("full3", 1'b1, 5'd22, 32'h22, bit_of(22) | bit_of(10) | bit_of(11));
        pipe(1'b1, 5'd23, 32'h23);
        tick();
        chk("full4.ready", {31'd0, mdu_ready}, 32'd0);
        chk_out("full4", 1'b1, 5'd23, 32'h23, bit_of(23) | bit_of(10) | bit_of(11));
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk_out("drain_r10", 1'b1, 5'd10, 32'h10, bit_of(10) | bit_of(11));
        chk("drain1.ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk_out("drain_r11", 1'b1, 5'd11, 32'h11, bit_of(11) | bit_of(12));
        mdu(1'b0, 5'd0, 32'd0);
        tick();
        chk_out("drain_r12", 1'b1, 5'd12, 32'h12, bit_of(12));
        tick();
        chk_out("drain_idle", 1'b0, 5'd0, 32'd0, 32'd0);

        // Squash: queued MDU r4 overtaken by pipe r4
        pipe(1'b1, 5'd25, 32'h25);
        mdu(1'b1, 5'd4, 32'h1);
        tick();
        chk_out("sq_queue", 1'b1, 5'd25, 32'h25, bit_of(25) | bit_of(4));
        mdu(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd4, 32'h2);
        tick();
        chk_out("sq_pipe", 1'b1, 5'd4, 32'h2, bit_of(4));
        pipe(1'b0, 5'd0, 32'd0);
        tick();
`ifdef WB_SQUASH_EN
        chk_out("sq_pop", 1'b0, 5'd0, 32'd0, 32'd0);
`else
        chk_out("sq_pop", 1'b1, 5'd4, 32'h1, bit_of(4));
`endif
        tick();
        chk_out("sq_idle", 1'b0, 5'd0, 32'd0, 32'd0);

        // r0 from both sources
        pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
        mdu(1'b1, 5'd0, 32'hFFFF_FFFF);
        chk("r0.ready_pre", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk_out("r0_n1", 1'b0, 5'd0, 32'd0, 32'd0);
        chk("r0_n1.ready", {31'd0, mdu_ready}, 32'd1);
        pipe(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        tick();
        chk_out("r0_n2", 1'b0, 5'd0, 32'd0, 32'd0);

        // Reset mid-operation discards the queue
        pipe(1'b1, 5'd1, 32'h11);
        mdu(1'b1, 5'd2, 32'h22);
        tick();
        chk_out("mid_pre", 1'b1, 5'd1, 32'h11, bit_of(1) | bit_of(2));
        pipe(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        #2;
        nRST = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 5'd0, 32'd0, 32'd0);
        chk("mid_rst.ready", {31'd0, mdu_ready}, 32'd1);
        #1;
        nRST = 1'b1;
        tick();
        chk_out("mid_after", 1'b0, 5'd0, 32'd0, 32'd0);
        pipe(1'b1, 5'd6, 32'h66);
        tick();
        chk_out("mid_first", 1'b1, 5'd6, 32'h66, bit_of(6));
        pipe(1'b0, 5'd0, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
